tick_gen_multi: RTL and testbench

//  Parametrised multi-channel strobe generator from the 100 MHz system clock.

---
 rtl/tick_gen_multi.sv | 123 ++++++++++++
 tb/tb_tick_gen_multi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// Multi-channel strobe generator: each channel emits a 1-cycle tick every N clocks
// plus a near-50% square enable, with N reprogrammable immediately or at the next wrap.
module tick_gen_multi #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 10,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100Mhz,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_immediate,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic              cfg_err
);

    // CH_W+1 bits always hold NUM_CH, so the range check works for power-of-two counts.
    logic cfg_ch_ok;
    logic cfg_div_ok;
    logic cfg_valid;
    logic cfg_err_q;
    logic cfg_err_d;

    assign cfg_ch_ok  = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign cfg_div_ok = (cfg_div >= DIV_W'(2));
    assign cfg_valid  = cfg_we && cfg_ch_ok && cfg_div_ok;
    assign cfg_err_d  = cfg_we && !cfg_valid;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_act_q, div_act_d;
        logic [DIV_W-1:0] div_pend_q, div_pend_d;
        logic             pend_v_q, pend_v_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             sel;
        logic             wrap;

        assign sel  = cfg_valid && (cfg_ch == CH_W'(i));
        assign wrap = (cnt_q >= div_act_q - DIV_W'(1));

        // NOTE: every signal driven here gets a default first, so no path
        // through the branches can leave one unassigned and infer a latch.
        always_comb begin
            cnt_d      = cnt_q;
            div_act_d  = div_act_q;
            div_pend_d = div_pend_q;
            pend_v_d   = pend_v_q;
            tick_d     = 1'b0;
            sq_d       = sq_q;

            if (sync_restart || (sel && cfg_immediate)) begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end else if (ch_en[i]) begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    sq_d   = 1'b1;
                    if (pend_v_q) begin
                        div_act_d = div_pend_q;
                        pend_v_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                    if (cnt_d == (div_act_q >> 1)) begin
                        sq_d = 1'b0;
                    end
                end
            end

            // A write landing on a wrap edge overrides the pend state the wrap just consumed.
            if (sel) begin
                if (cfg_immediate) begin
                    div_act_d = cfg_div;
                    pend_v_d  = 1'b0;
                end else begin
                    div_pend_d = cfg_div;
                    pend_v_d   = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_100Mhz or posedge reset) begin
            if (reset) begin
                cnt_q      <= '0;
                div_act_q  <= DIV_W'(DEF_DIV);
                div_pend_q <= DIV_W'(DEF_DIV);
                pend_v_q   <= 1'b0;
                tick_q     <= 1'b0;
                sq_q       <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                div_act_q  <= div_act_d;
                div_pend_q <= div_pend_d;
                pend_v_q   <= pend_v_d;
                tick_q     <= tick_d;
                sq_q       <= sq_d;
            end
        end

        assign tick[i] = tick_q;
        assign sq[i]   = sq_q;
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed scenarios plus randomized
// traffic compared against a period/phase model of each channel.
module tb_tick_gen_multi;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [15:0]    cfg_div = '0;
    logic           cfg_immediate = 1'b0;
    logic [NCH-1:0] ch_en = '1;
    logic           sync_restart = 1'b0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic           cfg_err;

    // Three-channel build, driven separately so its free-running ticks stay predictable.
    logic           cfg_we3 = 1'b0;
    logic [2:0]     ch_en3 = '1;
    logic           sync_restart3 = 1'b0;
    logic [2:0]     tick3;
    logic [2:0]     sq3;
    logic           cfg_err3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc3    = 0;

    // Model: phase within current period, active/pending period, and whether the
    // channel has completed a period since its last restart.
    int             pos     [NCH];
    int             n_act   [NCH];
    int             n_pend  [NCH];
    bit             pend    [NCH];
    bit             wrapped [NCH];
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_sq;
    logic           exp_err;

    always #5 clk = ~clk;

    tick_gen_multi #(.NUM_CH(NCH), .DIV_W(16), .DEF_DIV(10)) dut (
        .clk_100Mhz(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_immediate(cfg_immediate), .ch_en(ch_en),
        .sync_restart(sync_restart), .tick(tick), .sq(sq), .cfg_err(cfg_err)
    );

    tick_gen_multi #(.NUM_CH(3), .DIV_W(16), .DEF_DIV(10)) dut3 (
        .clk_100Mhz(clk), .reset(reset), .cfg_we(cfg_we3), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_immediate(cfg_immediate), .ch_en(ch_en3),
        .sync_restart(sync_restart3), .tick(tick3), .sq(sq3), .cfg_err(cfg_err3)
    );

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            pos[c] = 0; n_act[c] = 10; n_pend[c] = 10; pend[c] = 0; wrapped[c] = 0;
        end
        exp_tick = '0; exp_sq = '0; exp_err = 1'b0;
    endtask

    task automatic model_edge();
        bit valid;
        bit wr;
        valid   = cfg_we && (cfg_div >= 2) && (int'(cfg_ch) < NCH);
        exp_err = cfg_we && !valid;
        for (int c = 0; c < NCH; c++) begin
            wr = valid && (int'(cfg_ch) == c);
            exp_tick[c] = 1'b0;
            if (sync_restart || (wr && cfg_immediate)) begin
                pos[c] = 0; wrapped[c] = 0;
            end else if (ch_en[c]) begin
                pos[c]++;
                if (pos[c] == n_act[c]) begin
                    pos[c] = 0; exp_tick[c] = 1'b1; wrapped[c] = 1;
                    if (pend[c]) begin n_act[c] = n_pend[c]; pend[c] = 0; end
                end
            end
            if (wr) begin
                if (cfg_immediate) begin n_act[c] = int'(cfg_div); pend[c] = 0; end
                else begin n_pend[c] = int'(cfg_div); pend[c] = 1; end
            end
            exp_sq[c] = wrapped[c] && (pos[c] < n_act[c] / 2);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) begin model_reset(); cyc3 = 0; end
        else begin model_edge(); cyc3++; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        n_tests++;
        if ({tick, sq, cfg_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got tick=%b sq=%b err=%b, want all 0", tick, sq, cfg_err);
        end
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            n_tests++;
            if (tick !== ((k % 10 == 0) ? 4'hF : 4'h0) ||
                sq !== ((k >= 10 && (k % 10) < 5) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("FAIL default_period edge %0d: got tick=%b sq=%b", k, tick, sq);
            end
        end
    endtask

    task automatic test_immediate();
        repeat (4) cycle();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3; cfg_immediate = 1'b1;
        cycle();
        cfg_we = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            cycle();
            n_tests++;
            if (tick[1] !== (j % 3 == 0) || sq[1] !== (j % 3 == 0 || j % 3 == 1) && j >= 3 && (j % 3 == 0)) begin
                n_fail++;
                $display("FAIL immediate_ch1 edge %0d: got tick1=%b sq1=%b", j, tick[1], sq[1]);
            end
            n_tests++;
            if ({tick, sq} !== {exp_tick, exp_sq}) begin
                n_fail++;
                $display("FAIL immediate_all edge %0d: got %b/%b want %b/%b", j, tick, sq, exp_tick, exp_sq);
            end
        end
    endtask

    task automatic test_deferred();
        sync_restart = 1'b1;
        cycle();
        sync_restart = 1'b0;
        repeat (5) cycle();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd4; cfg_immediate = 1'b0;
        cycle();
        cfg_we = 1'b0;
        for (int k = 7; k <= 22; k++) begin
            cycle();
            n_tests++;
            if (tick[2] !== (k == 10 || k == 14 || k == 18 || k == 22)) begin
                n_fail++;
                $display("FAIL deferred_ch2 edge %0d: got tick2=%b", k, tick[2]);
            end
            n_tests++;
            if ({tick, sq} !== {exp_tick, exp_sq}) begin
                n_fail++;
                $display("FAIL deferred_all edge %0d: got %b/%b want %b/%b", k, tick, sq, exp_tick, exp_sq);
            end
        end
        // Two deferred writes before the next wrap: only the later one takes effect.
        cfg_we = 1'b1; cfg_div = 16'd4; cycle();
        cfg_div = 16'd7; cycle();
        cfg_we = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_tests++;
            if ({tick, sq, cfg_err} !== {exp_tick, exp_sq, exp_err}) begin
                n_fail++;
                $display("FAIL deferred_override cyc %0d: got %b/%b want %b/%b", k, tick, sq, exp_tick, exp_sq);
            end
        end
    endtask

    task automatic test_invalid();
        for (int v = 0; v < 2; v++) begin
            cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'(v); cfg_immediate = v[0];
            cycle();
            cfg_we = 1'b0;
            n_tests++;
            if (cfg_err !== 1'b1) begin
                n_fail++;
                $display("FAIL invalid_div%0d_err: got %b want 1", v, cfg_err);
            end
            cycle();
            n_tests++;
            if (cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_div%0d_pulse: got %b want 0", v, cfg_err);
            end
        end
        for (int k = 0; k < 12; k++) begin
            cycle();
            n_tests++;
            if ({tick, sq, cfg_err} !== {exp_tick, exp_sq, exp_err}) begin
                n_fail++;
                $display("FAIL invalid_periods cyc %0d: got %b/%b want %b/%b", k, tick, sq, exp_tick, exp_sq);
            end
        end
        // Channel 3 does not exist in the three-channel build.
        cfg_we3 = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd5; cfg_immediate = 1'b1;
        cycle();
        cfg_we3 = 1'b0;
        n_tests++;
        if (cfg_err3 !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_channel_err: got %b want 1", cfg_err3);
        end
        for (int k = 0; k < 12; k++) begin
            cycle();
            n_tests++;
            if (tick3 !== ((cyc3 % 10 == 0) ? 3'b111 : 3'b000) || cfg_err3 !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_channel_nochange edge %0d: got tick3=%b err3=%b", cyc3, tick3, cfg_err3);
            end
        end
    endtask

    task automatic test_disable();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd10; cfg_immediate = 1'b1;
        cycle();
        cfg_we = 1'b0;
        repeat (4) cycle();
        ch_en[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            n_tests++;
            if (tick[0] !== 1'b0 || {tick, sq} !== {exp_tick, exp_sq}) begin
                n_fail++;
                $display("FAIL disable_hold cyc %0d: got %b/%b want %b/%b", k, tick, sq, exp_tick, exp_sq);
            end
        end
        ch_en[0] = 1'b1;
        // Write edge + 4 enabled + 7 disabled: next tick 6 edges after re-enable, edge 17.
        for (int k = 12; k <= 20; k++) begin
            cycle();
            n_tests++;
            if (tick[0] !== (k == 17) || {tick, sq} !== {exp_tick, exp_sq}) begin
                n_fail++;
                $display("FAIL disable_resume edge %0d: got %b/%b want %b/%b", k, tick, sq, exp_tick, exp_sq);
            end
        end
        sync_restart = 1'b1;
        cycle();
        sync_restart = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            n_tests++;
            if ({tick, sq} !== {exp_tick, exp_sq}) begin
                n_fail++;
                $display("FAIL sync_restart cyc %0d: got %b/%b want %b/%b", k, tick, sq, exp_tick, exp_sq);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            cfg_we        = ($urandom_range(0, 7) == 0);
            cfg_ch        = 2'($urandom_range(0, 3));
            cfg_div       = 16'($urandom_range(0, 12));
            cfg_immediate = $urandom_range(0, 1) == 1;
            ch_en         = 4'($urandom) | 4'($urandom);
            sync_restart  = ($urandom_range(0, 63) == 0);
            cycle();
            n_tests++;
            if ({tick, sq, cfg_err} !== {exp_tick, exp_sq, exp_err}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b/%b/%b want %b/%b/%b",
                         k, tick, sq, cfg_err, exp_tick, exp_sq, exp_err);
            end
        end
        cfg_we = 1'b0; sync_restart = 1'b0; ch_en = '1;
    endtask

    task automatic test_async_reset();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd4; cfg_immediate = 1'b0;
        cycle();
        cfg_div = 16'd1;
        cycle();
        cfg_we = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({tick, sq, cfg_err, tick3, sq3, cfg_err3} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got tick=%b sq=%b err=%b, want all 0", tick, sq, cfg_err);
        end
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            n_tests++;
            if (tick !== ((k % 10 == 0) ? 4'hF : 4'h0) || {tick, sq} !== {exp_tick, exp_sq}) begin
                n_fail++;
                $display("FAIL reset_restores_default edge %0d: got %b/%b want %b/%b", k, tick, sq, exp_tick, exp_sq);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_immediate();
        test_deferred();
        test_invalid();
        test_disable();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
